mp_control_fsm: RTL

MP_CONTROL_FSM -- requirements
Module: mp_control_fsm

---
 rtl/mp_pkg.sv | 23 ++
 rtl/mp_retire_counter.sv | 19 +
 rtl/mp_control_fsm.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mp_pkg.sv
// Shared encodings for the multi-cycle processor control path: FSM states and opcodes.
// Latency: none (constants only).
// Backpressure: not applicable.
package mp_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_LW   = 2'b01;
  localparam logic [1:0] OP_SW   = 2'b10;
  localparam logic [1:0] OP_J    = 2'b11;
  localparam logic [7:0] OP_HALT = 8'hFF;

  function automatic logic [1:0] opcode(input logic [7:0] instr);
    return instr[7:6];
  endfunction

endpackage

// File: rtl/mp_retire_counter.sv
// Wrapping 8-bit count of retired instructions.
// Latency: count reflects an inc pulse one clk edge later; wraps 255 -> 0.
// Backpressure: none, every inc pulse is counted.
module mp_retire_counter (
  input  logic       clk,
  input  logic       Reset,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      count <= 8'h00;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/mp_control_fsm.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB); MP_CTRL_HALT_EN adds HALT on ir=8'hFF.
// Latency: ADD 4, J 3, LW 5, SW 4 cycles at zero wait; each mem_ack-low cycle adds one.
// Backpressure: mem_req holds in FETCH/MEM until mem_ack; mem_ack with no request is ignored.
module mp_control_fsm
  import mp_pkg::*;
(
  input  logic       clk,
  input  logic       Reset,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_isel,
  output logic [7:0] ir,
  output logic       pc_en,
  output logic       pc_sel,
  output logic       rf_we,
  output logic       alu_src,
  output logic       wb_sel,
  output logic [2:0] state_o,
`ifdef MP_CTRL_HALT_EN
  output logic       halted,
`endif
  output logic [7:0] retired
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [1:0] op;
  logic       is_halt;
  logic       is_jump;
  logic       is_mem_op;
  logic       retire;

  assign op = opcode(ir);

`ifdef MP_CTRL_HALT_EN
  assign is_halt = (ir == OP_HALT);
`else
  assign is_halt = 1'b0;
`endif

  assign is_jump   = (op == OP_J) && !is_halt;
  assign is_mem_op = (op == OP_LW) || (op == OP_SW);

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      ST_FETCH:  if (mem_ack) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (is_halt) begin
          state_nxt = ST_HALT;
          retire    = 1'b1;
        end else if (op == OP_ADD) begin
          state_nxt = ST_WB;
        end else if (is_mem_op) begin
          state_nxt = ST_MEM;
        end else begin
          state_nxt = ST_FETCH;
          retire    = 1'b1;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (op == OP_SW) begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end else begin
            state_nxt = ST_WB;
          end
        end
      end
      ST_WB: begin
        state_nxt = ST_FETCH;
        retire    = 1'b1;
      end
`ifdef MP_CTRL_HALT_EN
      ST_HALT:   state_nxt = ST_HALT;
`endif
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_FETCH;
      ir    <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && mem_ack) begin
        ir <= mem_rdata;
      end
    end
  end

  // State is already FETCH while Reset is low; gating by Reset keeps the
  // request and PC strobe quiet during reset without waiting for a clock.
  assign mem_req  = Reset && (state == ST_FETCH || state == ST_MEM);
  assign mem_we   = (state == ST_MEM) && (op == OP_SW);
  assign mem_isel = (state != ST_MEM);
  // The fetch PC increment fires only on the completing cycle of the fetch.
  assign pc_en    = (Reset && state == ST_FETCH && mem_ack) ||
                    (state == ST_EXEC && is_jump);
  assign pc_sel   = (state == ST_EXEC) && is_jump;
  assign rf_we    = (state == ST_WB);
  assign alu_src  = (state == ST_EXEC || state == ST_MEM) && is_mem_op;
  assign wb_sel   = (state == ST_WB) && (op == OP_LW);
  assign state_o  = state;

`ifdef MP_CTRL_HALT_EN
  assign halted = (state == ST_HALT);
`endif

  mp_retire_counter u_retire_counter (
    .clk   (clk),
    .Reset (Reset),
    .inc   (retire),
    .count (retired)
  );

endmodule
